// File: rtl/ram_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_bist_ctrl
// Description : Built-in self-test initiator for a single-port synchronous
//               RAM. Writes a seeded address pattern over every location,
//               reads it back checking data and even parity, then repeats
//               the sequence with the inverted pattern.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               start, seed              - test request and pattern seed
//               dout, parity_out         - RAM read data and its parity
//               din, addr, wr_en, rd_en  - RAM command port
//               addr_en, dout_en,
//               blk_select               - RAM enables, high while busy
//               busy, done, pass         - test status
//               err_cnt, fail_valid,
//               fail_addr                - error count and first failure
// Revision    : 1.0 - initial release
// ============================================================================
module ram_bist_ctrl #(
    parameter int MEM_WIDTH    = 16,
    parameter int MEM_DEPTH    = 1024,
    parameter int ADD_SIZE     = 10,
    parameter int ADDR_LAT     = 0,
    parameter int DOUT_LAT     = 1,
    parameter int PARITY_CHECK = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MEM_WIDTH-1:0] seed,
    input  logic [MEM_WIDTH-1:0] dout,
    input  logic                 parity_out,
    output logic [MEM_WIDTH-1:0] din,
    output logic [ADD_SIZE-1:0]  addr,
    output logic                 addr_en,
    output logic                 dout_en,
    output logic                 blk_select,
    output logic                 wr_en,
    output logic                 rd_en,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_cnt,
    output logic                 fail_valid,
    output logic [ADD_SIZE-1:0]  fail_addr
);

    // Cycles from the address cycle of a read to the cycle its data is checked.
    localparam int                c_rd_lat     = ADDR_LAT + 1 + DOUT_LAT;
    localparam logic [ADD_SIZE-1:0] c_last_addr  = ADD_SIZE'(MEM_DEPTH - 1);
    localparam logic [1:0]        c_drain_last = 2'(c_rd_lat - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic                  w_last_addr;
    logic                  w_drain_end;
    logic                  w_wr_now;
    logic                  w_rd_now;
    logic                  w_busy;
    logic                  w_done;

    logic [ADD_SIZE-1:0]   r_addr;
    logic [1:0]            r_drain;
    logic                  r_pass;
    logic [MEM_WIDTH-1:0]  r_seed;
    logic [MEM_WIDTH-1:0]  w_pat_base;
    logic [MEM_WIDTH-1:0]  w_pat;

    logic [15:0]           r_err_cnt;
    logic                  r_fail_valid;
    logic [ADD_SIZE-1:0]   r_fail_addr;

    // Expected word and address of each outstanding read, aligned to dout.
    logic                  r_pv [c_rd_lat];
    logic [MEM_WIDTH-1:0]  r_pe [c_rd_lat];
    logic [ADD_SIZE-1:0]   r_pa [c_rd_lat];

    logic                  w_chk_v;
    logic                  w_data_err;
    logic                  w_par_err;
    logic                  w_mismatch;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_last_addr = (r_addr == c_last_addr);
        w_drain_end = (r_drain == c_drain_last);
        w_wr_now    = (r_state == S_WRITE);
        w_rd_now    = (r_state == S_READ);
        w_busy      = (r_state == S_WRITE) || (r_state == S_READ) || (r_state == S_DRAIN);
        w_done      = (r_state == S_DONE);
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next   = S_WRITE;
                    w_accept = 1'b1;
                end
            end
            S_WRITE: if (w_last_addr) w_next = S_READ;
            S_READ:  if (w_last_addr) w_next = S_DRAIN;
            S_DRAIN: if (w_drain_end) w_next = r_pass ? S_DONE : S_WRITE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------ address / pass
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_drain <= '0;
            r_pass  <= 1'b0;
            r_seed  <= '0;
        end else begin
            if (w_accept) begin
                r_seed <= seed;
                r_pass <= 1'b0;
            end else if ((r_state == S_DRAIN) && w_drain_end) begin
                r_pass <= 1'b1;
            end

            if ((w_wr_now || w_rd_now) && !w_last_addr) begin
                r_addr <= r_addr + ADD_SIZE'(1);
            end else begin
                r_addr <= '0;
            end

            if ((r_state == S_DRAIN) && !w_drain_end) begin
                r_drain <= r_drain + 2'd1;
            end else begin
                r_drain <= '0;
            end
        end
    end

    // Address is zero-extended or truncated to the word width by the cast.
    assign w_pat_base = r_seed ^ MEM_WIDTH'(r_addr);
    assign w_pat      = r_pass ? ~w_pat_base : w_pat_base;

    // ------------------------------------------------------ command outputs
    // With a pipelined RAM address, strobes and write data trail addr by one.
    if (ADDR_LAT == 0) begin : g_cmd_direct
        assign wr_en = w_wr_now;
        assign rd_en = w_rd_now;
        assign din   = w_wr_now ? w_pat : '0;
    end else begin : g_cmd_delayed
        logic                 r_wr_en;
        logic                 r_rd_en;
        logic [MEM_WIDTH-1:0] r_din;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_wr_en <= 1'b0;
                r_rd_en <= 1'b0;
                r_din   <= '0;
            end else begin
                r_wr_en <= w_wr_now;
                r_rd_en <= w_rd_now;
                r_din   <= w_wr_now ? w_pat : '0;
            end
        end
        assign wr_en = r_wr_en;
        assign rd_en = r_rd_en;
        assign din   = r_din;
    end

    assign addr       = r_addr;
    assign addr_en    = w_busy;
    assign dout_en    = w_busy;
    assign blk_select = w_busy;
    assign busy       = w_busy;
    assign done       = w_done;
    assign pass       = w_done && (r_err_cnt == 16'd0);

    // ------------------------------------------------------ read delay line
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_rd_lat; i++) begin
                r_pv[i] <= 1'b0;
                r_pe[i] <= '0;
                r_pa[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_rd_now;
            r_pe[0] <= w_pat;
            r_pa[0] <= r_addr;
            for (int i = 1; i < c_rd_lat; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pa[i] <= r_pa[i-1];
            end
        end
    end

    // ------------------------------------------------------------- checker
    // A data and a parity error on the same read count as one mismatch.
    assign w_chk_v    = r_pv[c_rd_lat-1];
    assign w_data_err = (dout != r_pe[c_rd_lat-1]);
    assign w_par_err  = (PARITY_CHECK != 0) && (parity_out != (^dout));
    assign w_mismatch = w_chk_v && (w_data_err || w_par_err);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt    <= '0;
            r_fail_valid <= 1'b0;
            r_fail_addr  <= '0;
        end else if (w_accept) begin
            r_err_cnt    <= '0;
            r_fail_valid <= 1'b0;
            r_fail_addr  <= '0;
        end else if (w_mismatch) begin
            if (r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
            if (!r_fail_valid) begin
                r_fail_valid <= 1'b1;
                r_fail_addr  <= r_pa[c_rd_lat-1];
            end
        end
    end

    assign err_cnt    = r_err_cnt;
    assign fail_valid = r_fail_valid;
    assign fail_addr  = r_fail_addr;

endmodule
`default_nettype wire

// File: tb/tb_ram_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_bist_ctrl
// Description : Self-checking bench for ram_bist_ctrl. Three controllers share
//               clk/rst/start/seed, each with a small behavioural RAM:
//                 inst 0: ADDR_LAT=0, DOUT_LAT=1, PARITY_CHECK=1
//                 inst 1: ADDR_LAT=1, DOUT_LAT=0, PARITY_CHECK=1
//                 inst 2: ADDR_LAT=0, DOUT_LAT=1, PARITY_CHECK=0
//               Faults (stuck bit 0 at location 5, inverted parity) are
//               injected into the RAM models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_bist_ctrl;

    localparam logic [2:0] c_cfg_al = 3'b010;
    localparam logic [2:0] c_cfg_dl = 3'b101;
    localparam logic [2:0] c_cfg_pc = 3'b011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic        fault_stuck = 1'b0;
    logic        fault_par = 1'b0;

    logic [15:0] din        [3];
    logic [3:0]  addr       [3];
    logic        addr_en    [3];
    logic        dout_en    [3];
    logic        blk_select [3];
    logic        wr_en      [3];
    logic        rd_en      [3];
    logic        busy       [3];
    logic        done       [3];
    logic        pass       [3];
    logic [15:0] err_cnt    [3];
    logic        fail_valid [3];
    logic [3:0]  fail_addr  [3];

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        wr;
        logic [3:0]  a;
        logic [15:0] d;
    } sb_t;

    sb_t exp_q[$];
    sb_t mon_e;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int AL = int'(c_cfg_al[g]);
        localparam int DL = int'(c_cfg_dl[g]);
        localparam int PC = int'(c_cfg_pc[g]);

        logic [15:0] mem [16];
        logic [15:0] rdata;
        logic [15:0] dout_l;
        logic [3:0]  ra;
        logic        par_l;

        ram_bist_ctrl #(
            .MEM_WIDTH   (16),
            .MEM_DEPTH   (16),
            .ADD_SIZE    (4),
            .ADDR_LAT    (AL),
            .DOUT_LAT    (DL),
            .PARITY_CHECK(PC)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start),
            .seed       (seed),
            .dout       (dout_l),
            .parity_out (par_l),
            .din        (din[g]),
            .addr       (addr[g]),
            .addr_en    (addr_en[g]),
            .dout_en    (dout_en[g]),
            .blk_select (blk_select[g]),
            .wr_en      (wr_en[g]),
            .rd_en      (rd_en[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .pass       (pass[g]),
            .err_cnt    (err_cnt[g]),
            .fail_valid (fail_valid[g]),
            .fail_addr  (fail_addr[g])
        );

        if (AL == 1) begin : g_areg
            logic [3:0] a_q;
            always_ff @(posedge clk) a_q <= addr[g];
            assign ra = a_q;
        end else begin : g_acomb
            assign ra = addr[g];
        end

        always_ff @(posedge clk) begin
            if (blk_select[g] && wr_en[g]) begin
                mem[ra] <= (fault_stuck && (ra == 4'd5)) ? (din[g] & 16'hFFFE) : din[g];
            end
            if (blk_select[g] && rd_en[g]) begin
                rdata <= mem[ra];
            end
        end

        if (DL == 1) begin : g_dreg
            always_ff @(posedge clk) dout_l <= rdata;
        end else begin : g_dcomb
            assign dout_l = rdata;
        end

        assign par_l = (^dout_l) ^ fault_par;
    end

    // Scoreboard: every strobe of instance 0 must match the next expected command.
    always @(negedge clk) begin
        if (wr_en[0] || rd_en[0]) begin
            checks++;
            if (wr_en[0] && rd_en[0]) begin
                errors++;
                $display("FAIL strobe_overlap: wr_en=1 rd_en=1 at %0t, required at most one", $time);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: wr_en=%0b rd_en=%0b addr=%0d at %0t, required no strobe",
                         wr_en[0], rd_en[0], addr[0], $time);
            end else begin
                mon_e = exp_q.pop_front();
                if ((mon_e.wr !== wr_en[0]) || (mon_e.a !== addr[0]) ||
                    (mon_e.wr && (mon_e.d !== din[0]))) begin
                    errors++;
                    $display("FAIL sb_cmd: got wr=%0b addr=%0d din=%h, required wr=%0b addr=%0d din=%h",
                             wr_en[0], addr[0], din[0], mon_e.wr, mon_e.a, mon_e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_expected(input logic [15:0] s);
        sb_t         e;
        logic [15:0] pat;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 16; a++) begin
                pat = s ^ 16'(a);
                if (p == 1) pat = ~pat;
                e.wr = 1'b1; e.a = 4'(a); e.d = pat;
                exp_q.push_back(e);
            end
            for (int a = 0; a < 16; a++) begin
                e.wr = 1'b0; e.a = 4'(a); e.d = 16'h0000;
                exp_q.push_back(e);
            end
        end
    endtask

    // Pulses start for one edge; returns #1 into the first busy cycle.
    task automatic launch(input logic [15:0] s);
        @(posedge clk); #1;
        start = 1'b1;
        seed  = s;
        push_expected(s);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts busy cycles until busy drops; ends on the first idle negedge.
    task automatic wait_idle(input int idx, output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy[idx]) break;
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b, required 0", busy[0]); end
        checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b, required 0", done[0]); end
        checks++; if (pass[0] !== 1'b0) begin errors++; $display("FAIL rst_pass: got %0b, required 0", pass[0]); end
        checks++; if (err_cnt[0] !== 16'd0) begin errors++; $display("FAIL rst_err_cnt: got %0d, required 0", err_cnt[0]); end
        checks++; if ({fail_valid[0], fail_addr[0]} !== 5'd0) begin errors++; $display("FAIL rst_fail: got %b, required 0", {fail_valid[0], fail_addr[0]}); end
        checks++; if ({wr_en[0], rd_en[0], addr[0], din[0]} !== 22'd0) begin errors++; $display("FAIL rst_cmd: got %h, required 0", {wr_en[0], rd_en[0], addr[0], din[0]}); end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if ({busy[i], done[i], pass[i], err_cnt[i], fail_valid[i], wr_en[i], rd_en[i], addr_en[i]} !== 23'd0) begin
                errors++;
                $display("FAIL rst_inst%0d: got %h, required 0", i,
                         {busy[i], done[i], pass[i], err_cnt[i], fail_valid[i], wr_en[i], rd_en[i], addr_en[i]});
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_fault_free();
        int          n;
        logic [15:0] m3;
        logic [15:0] exp_m3;
        launch(16'hA5A5);
        wait_idle(0, n);
        exp_m3 = ~(16'hA5A5 ^ 16'h0003);
        m3     = g_inst[0].mem[3];
        checks++; if (n !== 68) begin errors++; $display("FAIL ff_busy_len: got %0d, required 68", n); end
        checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL ff_done: got %0b, required 1", done[0]); end
        checks++; if (pass[0] !== 1'b1) begin errors++; $display("FAIL ff_pass: got %0b, required 1", pass[0]); end
        checks++; if (err_cnt[0] !== 16'd0) begin errors++; $display("FAIL ff_err_cnt: got %0d, required 0", err_cnt[0]); end
        checks++; if (fail_valid[0] !== 1'b0) begin errors++; $display("FAIL ff_fail_valid: got %0b, required 0", fail_valid[0]); end
        checks++; if (m3 !== exp_m3) begin errors++; $display("FAIL ff_mem3: got %h, required %h", m3, exp_m3); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL ff_sb_left: got %0d entries, required 0", exp_q.size()); end
        checks++; if (pass[2] !== 1'b1) begin errors++; $display("FAIL ff_pass_inst2: got %0b, required 1", pass[2]); end
    endtask

    task automatic test_addr_lead();
        int n;
        launch(16'h1234);
        @(negedge clk);
        checks++;
        if ({busy[1], wr_en[1], addr[1]} !== {1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL al_first: got busy=%0b wr_en=%0b addr=%0d, required busy=1 wr_en=0 addr=0", busy[1], wr_en[1], addr[1]);
        end
        @(negedge clk);
        checks++;
        if ({wr_en[1], addr[1], din[1]} !== {1'b1, 4'd1, 16'h1234}) begin
            errors++;
            $display("FAIL al_second: got wr_en=%0b addr=%0d din=%h, required wr_en=1 addr=1 din=1234", wr_en[1], addr[1], din[1]);
        end
        wait_idle(1, n);
        n = n + 2;
        checks++; if (n !== 68) begin errors++; $display("FAIL al_busy_len: got %0d, required 68", n); end
        checks++; if ({done[1], pass[1], err_cnt[1]} !== {1'b1, 1'b1, 16'd0}) begin errors++; $display("FAIL al_result: got done=%0b pass=%0b err=%0d, required 1 1 0", done[1], pass[1], err_cnt[1]); end
    endtask

    task automatic test_stuck();
        int n;
        fault_stuck = 1'b1;
        launch(16'h0000);
        wait_idle(0, n);
        fault_stuck = 1'b0;
        checks++; if (err_cnt[0] !== 16'd1) begin errors++; $display("FAIL st_err_cnt: got %0d, required 1", err_cnt[0]); end
        checks++; if (fail_addr[0] !== 4'd5) begin errors++; $display("FAIL st_fail_addr: got %0d, required 5", fail_addr[0]); end
        checks++; if (fail_valid[0] !== 1'b1) begin errors++; $display("FAIL st_fail_valid: got %0b, required 1", fail_valid[0]); end
        checks++; if ({done[0], pass[0]} !== 2'b10) begin errors++; $display("FAIL st_done_pass: got %b, required 10", {done[0], pass[0]}); end
        checks++; if ({err_cnt[1], fail_addr[1]} !== {16'd1, 4'd5}) begin errors++; $display("FAIL st_inst1: got err=%0d addr=%0d, required 1 5", err_cnt[1], fail_addr[1]); end
    endtask

    task automatic test_restart_done();
        int n;
        launch(16'hC3C3);
        checks++;
        if ({busy[0], done[0], err_cnt[0], fail_valid[0], fail_addr[0]} !== {1'b1, 1'b0, 16'd0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL rs_clear: got busy=%0b done=%0b err=%0d fv=%0b fa=%0d, required 1 0 0 0 0",
                     busy[0], done[0], err_cnt[0], fail_valid[0], fail_addr[0]);
        end
        wait_idle(0, n);
        checks++; if (n !== 68) begin errors++; $display("FAIL rs_busy_len: got %0d, required 68", n); end
        checks++; if (pass[0] !== 1'b1) begin errors++; $display("FAIL rs_pass: got %0b, required 1", pass[0]); end
    endtask

    task automatic test_parity();
        int n;
        fault_par = 1'b1;
        launch(16'h3C3C);
        wait_idle(0, n);
        fault_par = 1'b0;
        checks++; if (err_cnt[0] !== 16'd32) begin errors++; $display("FAIL par_err_cnt: got %0d, required 32", err_cnt[0]); end
        checks++; if ({fail_valid[0], fail_addr[0]} !== {1'b1, 4'd0}) begin errors++; $display("FAIL par_fail: got fv=%0b fa=%0d, required 1 0", fail_valid[0], fail_addr[0]); end
        checks++; if (pass[0] !== 1'b0) begin errors++; $display("FAIL par_pass: got %0b, required 0", pass[0]); end
        checks++; if (err_cnt[1] !== 16'd32) begin errors++; $display("FAIL par_inst1: got %0d, required 32", err_cnt[1]); end
        checks++; if ({pass[2], err_cnt[2]} !== {1'b1, 16'd0}) begin errors++; $display("FAIL par_off: got pass=%0b err=%0d, required 1 0", pass[2], err_cnt[2]); end
    endtask

    task automatic test_reset_abort();
        int n;
        launch(16'h5AA5);
        // Busy cycle 24: in the middle of the pass-0 read sweep.
        repeat (24) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({busy[i], done[i], pass[i], err_cnt[i], fail_valid[i], fail_addr[i], addr[i], din[i],
                 wr_en[i], rd_en[i], addr_en[i], dout_en[i], blk_select[i]} !== 48'd0) begin
                errors++;
                $display("FAIL ab_rst_inst%0d: got busy=%0b done=%0b err=%0d wr=%0b rd=%0b addr=%0d din=%h, required all 0",
                         i, busy[i], done[i], err_cnt[i], wr_en[i], rd_en[i], addr[i], din[i]);
            end
        end
        repeat (10) @(negedge clk);
        checks++; if ({busy[0], busy[1], err_cnt[0]} !== 18'd0) begin errors++; $display("FAIL ab_idle: got busy0=%0b busy1=%0b err=%0d, required 0", busy[0], busy[1], err_cnt[0]); end
        launch(16'h5AA5);
        wait_idle(0, n);
        checks++; if (n !== 68) begin errors++; $display("FAIL ab_rerun_len: got %0d, required 68", n); end
        checks++; if ({pass[0], pass[1]} !== 2'b11) begin errors++; $display("FAIL ab_rerun_pass: got %b, required 11", {pass[0], pass[1]}); end
    endtask

    task automatic test_start_busy();
        int n;
        launch(16'h0F0F);
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        seed  = 16'hFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(0, n);
        n = n + 11;
        checks++; if (n !== 68) begin errors++; $display("FAIL sb_busy_len: got %0d, required 68", n); end
        checks++; if ({done[0], pass[0]} !== 2'b11) begin errors++; $display("FAIL sb_result: got done=%0b pass=%0b, required 1 1", done[0], pass[0]); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL sb_queue_left: got %0d entries, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_fault_free();
        test_addr_lead();
        test_stuck();
        test_restart_done();
        test_parity();
        test_reset_abort();
        test_start_busy();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
